axi_read_slave_rr: RTL and testbench

//  AXI3-style read slave: per-ID queues for the AR channel, a round-robin arbiter and a burst engine.
//  - Supports FIXED, INCR and WRAP bursts of up to 16 beats (ARLEN 0..15).
//  - Drives a single-port synchronous device read interface.
//  - Sits between the interconnect read path and one memory/peripheral device.

---
 rtl/axi_read_slave_rr.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_read_slave_rr.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_slave_rr.sv
// AXI3 read slave with per-ID request queues, a round-robin arbiter
// and a burst engine driving a single-port synchronous device.
module axi_read_slave_rr #(
   parameter int BusWidth  = 32,
   parameter int TagBits   = 2,
   parameter int FifoDepth = 4
) (
   input  logic                ACLK,
   input  logic                ARESET,
   output logic [BusWidth-1:0] address_out,
   output logic                devread,
   input  logic [BusWidth-1:0] data_in,
   input  logic [TagBits-1:0]  ARID,
   input  logic [BusWidth-1:0] ARADDR,
   input  logic [3:0]          ARLEN,
   input  logic [1:0]          ARSIZE,
   input  logic [1:0]          ARBURST,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [TagBits-1:0]  RID,
   output logic [BusWidth-1:0] RDATA,
   output logic [1:0]          RRESP,
   output logic                RLAST,
   output logic                RVALID,
   input  logic                RREADY
);

   localparam int NumId = 1 << TagBits;
   localparam int PtrW  = $clog2(FifoDepth);
   localparam int CntW  = $clog2(FifoDepth + 1);
   localparam int BB    = BusWidth / 8;

   typedef struct packed {
      logic [BusWidth-1:0] addr;
      logic [3:0]          len;
      logic [1:0]          size;
      logic [1:0]          burst;
   } ar_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_BEAT  = 2'd2
   } state_t;

   ar_t              q_mem [NumId][FifoDepth];
   logic [PtrW-1:0]  q_wr  [NumId];
   logic [PtrW-1:0]  q_rd  [NumId];
   logic [CntW-1:0]  q_cnt [NumId];
   logic [CntW-1:0]  cnt_nxt [NumId];
   logic [NumId-1:0] q_full;
   logic [NumId-1:0] push_v;
   logic [NumId-1:0] pop_v;

   state_t              state;
   logic [TagBits-1:0]  rr_ptr;
   logic [TagBits-1:0]  pick_id;
   logic [TagBits-1:0]  idx;
   logic                pick_ok;
   logic                pop;
   logic                ar_fire;
   ar_t                 head;
   logic                head_err;
   logic [BusWidth-1:0] head_nb;
   logic [BusWidth-1:0] head_tot;

   logic [BusWidth-1:0] cur_addr;
   logic [1:0]          cur_size;
   logic [1:0]          cur_burst;
   logic [BusWidth-1:0] wrap_lb;
   logic [BusWidth-1:0] wrap_tot;
   logic [3:0]          beats_left;
   logic                cur_err;
   logic [BusWidth-1:0] nb_w;
   logic [BusWidth-1:0] nxt_addr;
   logic [BusWidth-1:0] wrap_a;

   function automatic logic ar_err(input ar_t e);
      logic bad_len;
      bad_len = !(e.len == 4'd1 || e.len == 4'd3 ||
                  e.len == 4'd7 || e.len == 4'd15);
      return ((1 << e.size) > BB) || (e.burst == 2'b11) ||
             (e.burst == 2'b10 && bad_len);
   endfunction

   // Byte lanes a narrow beat actually carries.
   function automatic logic [BusWidth-1:0] lane_mask(
      input logic [BusWidth-1:0] a,
      input logic [1:0]          sz
   );
      int nb;
      int al;
      int lo;
      int hi;
      logic [BusWidth-1:0] m;
      nb = 1 << sz;
      al = int'(a[7:0]) & ~(nb - 1);
      lo = int'(a[7:0]) % BB;
      hi = (al % BB) + nb - 1;
      m  = '0;
      for (int j = 0; j < BB; j++) begin
         if (j >= lo && j <= hi) m[j*8 +: 8] = 8'hFF;
      end
      return m;
   endfunction

   assign ARREADY = !ARESET && !q_full[ARID];
   assign ar_fire = ARVALID && ARREADY;
   assign pop     = (state == S_IDLE) && pick_ok && !ARESET;

   // Round-robin pick: first non-empty queue after the last one served.
   always_comb begin
      pick_ok = 1'b0;
      pick_id = '0;
      idx     = '0;
      for (int k = 1; k <= NumId; k++) begin
         idx = rr_ptr + TagBits'(k);
         if (!pick_ok && q_cnt[idx] != '0) begin
            pick_ok = 1'b1;
            pick_id = idx;
         end
      end
   end

   // Per-queue push/pop strobes and next occupancy.
   always_comb begin
      for (int i = 0; i < NumId; i++) begin
         push_v[i]  = ar_fire && (ARID == TagBits'(i));
         pop_v[i]   = pop && (pick_id == TagBits'(i));
         cnt_nxt[i] = q_cnt[i] + CntW'(push_v[i]) - CntW'(pop_v[i]);
      end
   end

   // Head entry of the picked queue and its burst geometry.
   always_comb begin
      head     = q_mem[pick_id][q_rd[pick_id]];
      head_err = ar_err(head);
      head_nb  = BusWidth'(1) << head.size;
      head_tot = head_nb * (BusWidth'(head.len) + BusWidth'(1));
   end

   // Next beat address for the active burst.
   always_comb begin
      nb_w   = BusWidth'(1) << cur_size;
      wrap_a = cur_addr + nb_w;
      if (wrap_a == wrap_lb + wrap_tot) wrap_a = wrap_lb;
      unique case (1'b1)
         cur_burst == 2'b00: nxt_addr = cur_addr;
         cur_burst == 2'b10: nxt_addr = wrap_a;
         default:            nxt_addr = (cur_addr & ~(nb_w - 1)) + nb_w;
      endcase
   end

   // Queue storage; contents need no reset, pointers guard validity.
   always_ff @(posedge ACLK) begin
      if (ar_fire) begin
         q_mem[ARID][q_wr[ARID]] <= '{ARADDR, ARLEN, ARSIZE, ARBURST};
      end
   end

   // Queue pointers, occupancy and registered full flags.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NumId; i++) begin
            q_wr[i]   <= '0;
            q_rd[i]   <= '0;
            q_cnt[i]  <= '0;
            q_full[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NumId; i++) begin
            if (push_v[i]) q_wr[i] <= q_wr[i] + 1'b1;
            if (pop_v[i])  q_rd[i] <= q_rd[i] + 1'b1;
            q_cnt[i]  <= cnt_nxt[i];
            q_full[i] <= (cnt_nxt[i] == CntW'(FifoDepth));
         end
      end
   end

   // Burst engine: IDLE picks, FETCH reads the device, BEAT presents R.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state       <= S_IDLE;
         rr_ptr      <= '0;
         cur_addr    <= '0;
         cur_size    <= '0;
         cur_burst   <= '0;
         wrap_lb     <= '0;
         wrap_tot    <= '0;
         beats_left  <= '0;
         cur_err     <= 1'b0;
         address_out <= '0;
         devread     <= 1'b0;
         RID         <= '0;
         RDATA       <= '0;
         RRESP       <= 2'b00;
         RLAST       <= 1'b0;
         RVALID      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  rr_ptr     <= pick_id;
                  RID        <= pick_id;
                  cur_addr   <= head.addr;
                  cur_size   <= head.size;
                  cur_burst  <= head.burst;
                  wrap_tot   <= head_tot;
                  wrap_lb    <= head.addr & ~(head_tot - BusWidth'(1));
                  beats_left <= head.len;
                  cur_err    <= head_err;
                  devread    <= !head_err;
                  if (!head_err) address_out <= head.addr;
                  state      <= S_FETCH;
               end
            end
            S_FETCH: begin
               devread <= 1'b0;
               RDATA   <= cur_err ? '0
                                  : (data_in & lane_mask(cur_addr, cur_size));
               RRESP   <= cur_err ? 2'b10 : 2'b00;
               RLAST   <= (beats_left == 4'd0);
               RVALID  <= 1'b1;
               state   <= S_BEAT;
            end
            S_BEAT: begin
               if (RREADY) begin
                  RVALID <= 1'b0;
                  if (RLAST) begin
                     state <= S_IDLE;
                  end else begin
                     cur_addr   <= nxt_addr;
                     beats_left <= beats_left - 4'd1;
                     devread    <= !cur_err;
                     if (!cur_err) address_out <= nxt_addr;
                     state      <= S_FETCH;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_slave_rr.sv
// Randomized scoreboard bench for axi_read_slave_rr.
// Expected beats are pushed on AR acceptance, popped as R beats appear.
module tb_axi_read_slave_rr;

   localparam int FD = 4;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic [31:0] address_out;
   logic        devread;
   logic [31:0] data_in;
   logic [1:0]  ARID = '0;
   logic [31:0] ARADDR = '0;
   logic [3:0]  ARLEN = '0;
   logic [1:0]  ARSIZE = '0;
   logic [1:0]  ARBURST = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [1:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   axi_read_slave_rr #(
      .BusWidth(32), .TagBits(2), .FifoDepth(FD)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .address_out(address_out), .devread(devread), .data_in(data_in),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
      .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [31:0] dev_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   assign data_in = dev_data(address_out);

   typedef struct {
      logic [1:0]  id;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic        err;
   } beat_t;

   beat_t       exq[$];
   int          order[$];
   logic [31:0] addr_log[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          rr_mode = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] a, input int nb);
      logic [31:0] m;
      int lo;
      int hi;
      lo = int'(a % 4);
      hi = int'((a - a % nb) % 4) + nb - 1;
      m = '0;
      for (int j = 0; j < 4; j++)
         if (j >= lo && j <= hi) m[j*8 +: 8] = 8'hFF;
      return m;
   endfunction

   // Reference: expand one accepted request into its list of beats.
   task automatic model_push(input logic [1:0] id, input logic [31:0] a,
                             input logic [3:0] len, input logic [1:0] size,
                             input logic [1:0] burst);
      int nb;
      int beats;
      logic [31:0] tot;
      logic [31:0] lb;
      logic [31:0] ad;
      bit err;
      beat_t b;
      nb    = 1 << size;
      beats = int'(len) + 1;
      tot   = 32'(nb * beats);
      err   = (nb > 4) || (burst == 2'b11) ||
              (burst == 2'b10 && !(len == 1 || len == 3 ||
                                   len == 7 || len == 15));
      lb = a - (a % tot);
      for (int i = 0; i < beats; i++) begin
         case (burst)
            2'b00:   ad = a;
            2'b01:   ad = (i == 0) ? a : (a - a % nb) + 32'(i * nb);
            2'b10:   ad = lb + (((a - lb) + 32'(i * nb)) % tot);
            default: ad = a;
         endcase
         b.id   = id;
         b.addr = ad;
         b.data = err ? 32'h0 : (dev_data(ad) & lanes(ad, nb));
         b.resp = err ? 2'b10 : 2'b00;
         b.last = (i == beats - 1);
         b.err  = err;
         exq.push_back(b);
      end
   endtask

   // RREADY pattern: 0 = always ready, 1 = stalled, 2 = random.
   always @(posedge ACLK) begin
      #1;
      RREADY = (rr_mode == 0) ? 1'b1 :
               (rr_mode == 1) ? 1'b0 : ($urandom % 4 != 0);
   end

   logic        seen = 1'b0;
   logic [31:0] seen_addr = '0;
   logic        pv = 1'b0;
   logic [31:0] p_data;
   logic [1:0]  p_id;
   logic [1:0]  p_resp;
   logic        p_last;

   // Monitor: record requests, device reads and check every R beat.
   always @(negedge ACLK) begin
      if (ARESET) begin
         exq.delete();
         seen = 1'b0;
         pv   = 1'b0;
      end else begin
         if (ARVALID && ARREADY)
            model_push(ARID, ARADDR, ARLEN, ARSIZE, ARBURST);
         if (devread) begin
            check("one_devread_per_beat", seen, 1'b0);
            seen      = 1'b1;
            seen_addr = address_out;
            addr_log.push_back(address_out);
         end
         if (RVALID && !RREADY) begin
            if (pv) begin
               check("stall_rdata", RDATA, p_data);
               check("stall_rid", RID, p_id);
               check("stall_rresp", RRESP, p_resp);
               check("stall_rlast", RLAST, p_last);
            end
            pv = 1'b1;
            p_data = RDATA;
            p_id   = RID;
            p_resp = RRESP;
            p_last = RLAST;
         end else begin
            pv = 1'b0;
         end
         if (RVALID && RREADY) begin
            int k;
            k = -1;
            for (int i = 0; i < exq.size(); i++)
               if (k < 0 && exq[i].id == RID) k = i;
            check("beat_expected", k >= 0, 1'b1);
            if (k >= 0) begin
               check("rdata", RDATA, exq[k].data);
               check("rresp", RRESP, exq[k].resp);
               check("rlast", RLAST, exq[k].last);
               if (exq[k].err) begin
                  check("no_devread_on_err", seen, 1'b0);
               end else begin
                  check("devread_seen", seen, 1'b1);
                  check("address_out", seen_addr, exq[k].addr);
               end
               if (exq[k].last) order.push_back(int'(RID));
               exq.delete(k);
            end
            seen = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic send_ar(input logic [1:0] id, input logic [31:0] a,
                          input logic [3:0] len, input logic [1:0] size,
                          input logic [1:0] burst);
      bit ok;
      ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge ACLK);
         if (ARREADY) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      ARVALID = 1'b0;
      if (!ok) check("ar_accept_timeout", ok, 1'b1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 1'b0;
      for (int t = 0; t < 5000; t++) begin
         @(negedge ACLK);
         if (exq.size() == 0 && !RVALID) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("drain_timeout", done, 1'b1);
      repeat (3) step();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          ls;
      int          acc;
      int          os;
      int          cnt;
      logic [31:0] e1[4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
      logic [31:0] e2[4] = '{32'h34, 32'h38, 32'h3C, 32'h30};
      int          eo[6] = '{1, 2, 1, 2, 1, 2};
      logic [1:0]  rs;
      logic [31:0] ra;

      // Reset state.
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_arready", ARREADY, 1'b0);
      check("rst_rvalid", RVALID, 1'b0);
      check("rst_rlast", RLAST, 1'b0);
      check("rst_rdata", RDATA, 32'h0);
      check("rst_rresp", RRESP, 2'b00);
      check("rst_rid", RID, 2'b00);
      check("rst_devread", devread, 1'b0);
      check("rst_address_out", address_out, 32'h0);
      step();
      ARESET = 1'b0;
      step();

      // INCR burst and first-beat latency.
      ls = addr_log.size();
      send_ar(2'd0, 32'h10, 4'd3, 2'd2, 2'b01);
      lat = 1;
      for (int t = 0; t < 20; t++) begin
         @(negedge ACLK);
         if (RVALID) break;
         lat++;
      end
      check("first_beat_latency", lat, 3);
      wait_drain();
      check("incr_beats", addr_log.size() - ls, 4);
      for (int k = 0; k < 4; k++) check("incr_addr", addr_log[ls+k], e1[k]);

      // WRAP burst.
      ls = addr_log.size();
      send_ar(2'd1, 32'h34, 4'd3, 2'd2, 2'b10);
      wait_drain();
      check("wrap_beats", addr_log.size() - ls, 4);
      for (int k = 0; k < 4; k++) check("wrap_addr", addr_log[ls+k], e2[k]);

      // FIXED narrow burst.
      ls = addr_log.size();
      send_ar(2'd2, 32'h21, 4'd1, 2'd0, 2'b00);
      wait_drain();
      check("fixed_beats", addr_log.size() - ls, 2);
      check("fixed_addr0", addr_log[ls], 32'h21);
      check("fixed_addr1", addr_log[ls+1], 32'h21);

      // Oversize beat: errored burst, no device reads.
      ls = addr_log.size();
      os = n_tests;
      send_ar(2'd3, 32'h40, 4'd1, 2'd3, 2'b01);
      wait_drain();
      check("err_no_devread", addr_log.size() - ls, 0);

      // Round-robin service order between ID1 and ID2.
      rr_mode = 1;
      step(); step();
      os = order.size();
      for (int k = 0; k < 3; k++) send_ar(2'd1, 32'h100 + 32'(k * 16), 4'd0, 2'd2, 2'b01);
      for (int k = 0; k < 3; k++) send_ar(2'd2, 32'h200 + 32'(k * 16), 4'd0, 2'd2, 2'b01);
      rr_mode = 0;
      wait_drain();
      check("rr_bursts", order.size() - os, 6);
      for (int k = 0; k < 6; k++) check("rr_order", order[os+k], eo[k]);

      // Fill one queue while the engine is stalled.
      rr_mode = 1;
      step(); step();
      ARID = 2'd3; ARADDR = 32'h300; ARLEN = 4'd0; ARSIZE = 2'd2;
      ARBURST = 2'b01; ARVALID = 1'b1;
      acc = 0;
      for (int t = 0; t < 12; t++) begin
         @(negedge ACLK);
         if (!ARREADY) break;
         acc++;
         step();
      end
      check("fill_accepted", acc, FD + 1);
      check("arready_when_full", ARREADY, 1'b0);
      step();
      ARVALID = 1'b0;
      rr_mode = 0;
      wait_drain();

      // Stall mid-burst, queue more work, then reset.
      send_ar(2'd0, 32'h500, 4'd7, 2'd2, 2'b01);
      repeat (5) step();
      rr_mode = 1;
      send_ar(2'd2, 32'h600, 4'd3, 2'd2, 2'b01);
      send_ar(2'd1, 32'h700, 4'd1, 2'd1, 2'b01);
      repeat (6) step();
      ARESET = 1'b1;
      ARID = 2'd3; ARVALID = 1'b1;
      @(negedge ACLK);
      check("arready_in_reset", ARREADY, 1'b0);
      step();
      ARESET = 1'b0;
      ARVALID = 1'b0;
      @(negedge ACLK);
      check("post_rst_rvalid", RVALID, 1'b0);
      check("post_rst_rlast", RLAST, 1'b0);
      check("post_rst_devread", devread, 1'b0);
      rr_mode = 0;
      cnt = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge ACLK);
         if (RVALID || devread) cnt++;
      end
      check("queues_empty_after_rst", cnt, 0);
      check("arready_after_rst", ARREADY, 1'b1);
      step();
      send_ar(2'd2, 32'h800, 4'd2, 2'd2, 2'b01);
      wait_drain();

      // Randomized traffic with random back-pressure.
      rr_mode = 2;
      for (int n = 0; n < 80; n++) begin
         rs = 2'($urandom_range(0, 3));
         ra = $urandom;
         if ($urandom_range(0, 3) == 0) rs = 2'd2;
         ARBURST = 2'($urandom_range(0, 3));
         if (ARBURST == 2'b10) ra = ra & ~((32'd1 << rs) - 32'd1);
         send_ar(2'($urandom_range(0, 3)), ra, 4'($urandom_range(0, 15)),
                 rs, ARBURST);
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) step();
      end
      rr_mode = 0;
      wait_drain();
      check("scoreboard_empty", exq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
